// File: rtl/prewish_mask_sequencer.sv
// rtl/prewish_mask_sequencer.sv - event-driven mask source with strobe handshake for the prewish mentor
module prewish_mask_sequencer #(
  parameter int                 DATA_W        = 8,
  parameter int                 PERIOD        = 60_000_000,
  parameter int                 STB_CYCLES    = 1,
  parameter int                 DEBOUNCE_BITS = 16,
  parameter logic [DATA_W-1:0]  LFSR_TAPS     = 8'hB8,
  parameter logic [DATA_W-1:0]  LFSR_SEED     = 8'h01
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] dip_i,
  input  logic              btn_i,
  output logic              STB_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic              busy_o
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SC_W  = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

  logic [CNT_W-1:0]         per_q;
  logic                     tick_q;
  logic                     btn_s1_q, btn_s2_q, db_q;
  logic [DEBOUNCE_BITS-1:0] dbc_q;
  logic                     press;
  logic                     ev;
  state_t                   state_q, state_d;
  logic [SC_W-1:0]          sc_q, sc_d;
  logic                     pend_q, pend_d;
  logic [DATA_W-1:0]        dat_q, dat_d, next_mask;
  logic                     start;

  // Tick is registered so it lines up one cycle behind the terminal count.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      per_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= en_i && (per_q == CNT_LAST);
      if (en_i) begin
        per_q <= (per_q == CNT_LAST) ? '0 : per_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      db_q     <= 1'b0;
      dbc_q    <= '0;
    end else begin
      btn_s1_q <= btn_i;
      btn_s2_q <= btn_s1_q;
      if (btn_s2_q == db_q) begin
        dbc_q <= '0;
      end else if (&dbc_q) begin
        dbc_q <= '0;
        db_q  <= ~db_q;
      end else begin
        dbc_q <= dbc_q + DEBOUNCE_BITS'(1);
      end
    end
  end

  assign press = (btn_s2_q != db_q) && (&dbc_q) && btn_s2_q;
  assign ev    = ((mode_i == 2'b11) ? press : tick_q) | load_i;

  always_comb begin
    next_mask = dat_q;
    case (mode_i)
      2'b00:   next_mask = dat_q - DATA_W'(1);
      2'b01:   next_mask = dat_q + DATA_W'(1);
      2'b10:   next_mask = (dat_q == '0) ? LFSR_SEED
                         : ((dat_q >> 1) ^ (dat_q[0] ? LFSR_TAPS : '0));
      default: next_mask = dip_i;
    endcase
  end

  // An event arriving in GAP is served by the back-to-back strobe, so it coalesces with pending.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    pend_d  = pend_q;
    dat_d   = dat_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev) start = 1'b1;
      end
      S_STROBE: begin
        if (ev) pend_d = 1'b1;
        if (sc_q == SC_LAST) state_d = S_GAP;
        else                 sc_d    = sc_q + SC_W'(1);
      end
      S_GAP: begin
        if (pend_q || ev) start   = 1'b1;
        else              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_STROBE;
      sc_d    = '0;
      pend_d  = 1'b0;
      dat_d   = next_mask;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      pend_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      pend_q  <= pend_d;
      dat_q   <= dat_d;
    end
  end

  assign STB_O  = (state_q == S_STROBE);
  assign busy_o = STB_O;
  assign DAT_O  = dat_q;

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// tb/tb_prewish_mask_sequencer.sv - directed vector bench for prewish_mask_sequencer
module tb_prewish_mask_sequencer;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] dip;
    logic [7:0] exp_dat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] dip = 8'h00;
  logic       btn = 1'b0;
  logic       stb, busy;
  logic [7:0] dat;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rises = 0;
  int   snap;
  logic prev_stb = 1'b0;
  vec_t vt [8];

  prewish_mask_sequencer #(
    .DATA_W(8), .PERIOD(10), .STB_CYCLES(2), .DEBOUNCE_BITS(2),
    .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)
  ) dut (
    .CLK_I(clk), .RST_I(rst_n), .en_i(en), .mode_i(mode), .load_i(load),
    .dip_i(dip), .btn_i(btn), .STB_O(stb), .DAT_O(dat), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (stb && !prev_stb) rises++;
    prev_stb = stb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic exp_stb, input logic [7:0] exp_dat);
    chk({name, ".stb"}, 32'(stb), 32'(exp_stb));
    chk({name, ".busy"}, 32'(busy), 32'(exp_stb));
    chk({name, ".dat"}, 32'(dat), 32'(exp_dat));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b01, 8'h00, 8'hFE};
    vt[1] = '{2'b01, 8'h00, 8'hFF};
    vt[2] = '{2'b01, 8'h00, 8'h00};
    vt[3] = '{2'b10, 8'h00, 8'h01};
    vt[4] = '{2'b10, 8'h00, 8'hB8};
    vt[5] = '{2'b10, 8'h00, 8'h5C};
    vt[6] = '{2'b11, 8'h3C, 8'h3C};
    vt[7] = '{2'b00, 8'h00, 8'h3B};

    // reset, then period ticks in decrement mode
    en = 1'b1;
    cyc(3);
    chk_out("reset", 1'b0, 8'h00);
    rst_n = 1'b1;
    cyc(10);
    chk("t1_before_first", 32'(stb), 32'd0);
    cyc(1);
    chk_out("t1_first", 1'b1, 8'hFF);
    cyc(1);
    chk("t1_first_len", 32'(stb), 32'd1);
    cyc(1);
    chk("t1_gap", 32'(stb), 32'd0);
    cyc(7);
    chk("t1_before_second", 32'(stb), 32'd0);
    cyc(1);
    chk_out("t1_second", 1'b1, 8'hFE);

    // load coinciding with the next tick
    snap = rises;
    cyc(9);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    en = 1'b0;
    chk_out("t2_tick_load", 1'b1, 8'hFD);
    cyc(10);
    chk("t2_one_strobe", 32'(rises - snap), 32'd1);

    for (int i = 0; i < 8; i++) begin
      mode = vt[i].mode;
      dip  = vt[i].dip;
      cyc(2);
      chk($sformatf("vec%0d_idle", i), 32'(stb), 32'd0);
      pulse_load();
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].exp_dat);
      cyc(1);
      chk($sformatf("vec%0d_len", i), 32'(stb), 32'd1);
      cyc(1);
      chk($sformatf("vec%0d_gap", i), 32'(stb), 32'd0);
      cyc(1);
    end

    // manual mode: button debounce, ticks ignored
    mode = 2'b11;
    dip  = 8'hA5;
    en   = 1'b1;
    snap = rises;
    btn  = 1'b1;
    cyc(3);
    btn  = 1'b0;
    cyc(12);
    chk("t4_short_press", 32'(rises - snap), 32'd0);
    snap = rises;
    btn  = 1'b1;
    cyc(10);
    btn  = 1'b0;
    cyc(25);
    chk("t4_long_press", 32'(rises - snap), 32'd1);
    chk("t4_dip", 32'(dat), 32'hA5);
    en = 1'b0;

    // events during STROBE and GAP coalesce into one extra strobe
    mode = 2'b01;
    cyc(2);
    snap = rises;
    load = 1'b1;
    cyc(1);
    chk_out("t5_first", 1'b1, 8'hA6);
    cyc(1);
    load = 1'b0;
    chk("t5_strobe2", 32'(stb), 32'd1);
    cyc(1);
    chk("t5_gap", 32'(stb), 32'd0);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk_out("t5_extra", 1'b1, 8'hA7);
    cyc(10);
    chk("t5_strobe_count", 32'(rises - snap), 32'd2);
    chk("t5_final_dat", 32'(dat), 32'hA7);

    // asynchronous reset mid-strobe
    pulse_load();
    chk_out("t6_before_rst", 1'b1, 8'hA8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    snap = rises;
    cyc(15);
    chk("t6_no_strobe", 32'(rises - snap), 32'd0);
    chk_out("t6_idle", 1'b0, 8'h00);
    pulse_load();
    chk_out("t6_after", 1'b1, 8'h01);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
